// File: rtl/riscv_pkg.sv
// Shared definitions for the ID/EX stage: datapath width, ALU op codes,
// stage FSM encoding and the operand-forwarding priority function.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;
    localparam logic [3:0] ALU_LUI  = 4'hA;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } stage_state_e;

    typedef enum logic [1:0] {
        FWD_ZERO = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2,
        FWD_RF   = 2'd3
    } fwd_sel_e;

    // x0 is hardwired; the MEM-stage producer is younger than WB so it wins.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_wen,
        input logic [4:0] wb_rd,
        input logic       wb_wen
    );
        if (rs == 5'd0)
            return FWD_ZERO;
        else if (mem_wen && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_wen && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand selector for one source register: zero, MEM bypass, WB bypass
// or register-file data.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [4:0]       rs,
    input  logic [WIDTH-1:0] rf_data,
    input  logic [4:0]       mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             mem_wen,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             wb_wen,
    output logic [WIDTH-1:0] operand
);

    fwd_sel_e sel;

    assign sel = fwd_select(rs, mem_rd, mem_wen, wb_rd, wb_wen);

    always_comb begin
        operand = rf_data;
        case (sel)
            FWD_ZERO: operand = '0;
            FWD_MEM:  operand = mem_data;
            FWD_WB:   operand = wb_data;
            default:  operand = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-entry skid with operand forwarding, load-use
// bubble insertion, flush, and WB snooping of a stalled instruction's operands.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd_in,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [WIDTH-1:0] imm_in,
    input  logic [3:0]       alu_op_in,
    input  logic             reg_wen_in,
    input  logic             mem_read_in,
    input  logic [4:0]       mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             mem_wen,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             wb_wen,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] imm_out,
    output logic [4:0]       rd_out,
    output logic [3:0]       alu_op_out,
    output logic             reg_wen_out,
    output logic             mem_read_out
);

    stage_state_e state_reg, state_next;
    logic [4:0]   rs1_held_reg, rs2_held_reg;
    logic         hazard, accept, hold;
    logic         snoop_a, snoop_b;

    logic [1:0][4:0]       src_idx;
    logic [1:0][WIDTH-1:0] src_rf;
    logic [1:0][WIDTH-1:0] src_fwd;

    assign src_idx[0] = rs1;
    assign src_idx[1] = rs2;
    assign src_rf[0]  = dataA;
    assign src_rf[1]  = dataB;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_mux #(.WIDTH(WIDTH)) u_fwd_mux (
                .rs       (src_idx[gi]),
                .rf_data  (src_rf[gi]),
                .mem_rd   (mem_rd),
                .mem_data (mem_data),
                .mem_wen  (mem_wen),
                .wb_rd    (wb_rd),
                .wb_data  (wb_data),
                .wb_wen   (wb_wen),
                .operand  (src_fwd[gi])
            );
        end
    endgenerate

    // A load sitting in the output register whose result the incoming instruction needs.
    assign hazard = out_valid && mem_read_out && (rd_out != 5'd0)
                    && ((rd_out == rs1) || (rd_out == rs2)) && in_valid;

    assign in_ready = (!out_valid || out_ready) && (state_reg == RUN) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign hold     = out_valid && !out_ready && !flush;

    assign snoop_a = wb_wen && (rs1_held_reg != 5'd0) && (wb_rd == rs1_held_reg);
    assign snoop_b = wb_wen && (rs2_held_reg != 5'd0) && (wb_rd == rs2_held_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (hazard && out_ready) state_next = BUBBLE;
            BUBBLE:  state_next = RUN;
            default: state_next = RUN;
        endcase
        if (flush) state_next = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= RUN;
        else        state_reg <= state_next;
    end

    // Anything that is neither a new transfer nor a stall leaves a zeroed bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            opA          <= '0;
            opB          <= '0;
            imm_out      <= '0;
            rd_out       <= '0;
            alu_op_out   <= '0;
            reg_wen_out  <= 1'b0;
            mem_read_out <= 1'b0;
            rs1_held_reg <= '0;
            rs2_held_reg <= '0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            opA          <= src_fwd[0];
            opB          <= src_fwd[1];
            imm_out      <= imm_in;
            rd_out       <= rd_in;
            alu_op_out   <= alu_op_in;
            reg_wen_out  <= reg_wen_in;
            mem_read_out <= mem_read_in;
            rs1_held_reg <= rs1;
            rs2_held_reg <= rs2;
        end else if (hold) begin
            if (snoop_a) opA <= wb_data;
            if (snoop_b) opB <= wb_data;
        end else begin
            out_valid    <= 1'b0;
            opA          <= '0;
            opB          <= '0;
            imm_out      <= '0;
            rd_out       <= '0;
            alu_op_out   <= '0;
            reg_wen_out  <= 1'b0;
            mem_read_out <= 1'b0;
            rs1_held_reg <= '0;
            rs2_held_reg <= '0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table of single transfers plus
// hand-written load-use, stall/snoop, flush and reset sequences.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  rs1, rs2, rd_in;
    logic [31:0] dataA, dataB, imm_in;
    logic [3:0]  alu_op_in;
    logic        reg_wen_in, mem_read_in;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_wen;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] opA, opB, imm_out;
    logic [4:0]  rd_out;
    logic [3:0]  alu_op_out;
    logic        reg_wen_out, mem_read_out;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd_in(rd_in),
        .dataA(dataA), .dataB(dataB),
        .imm_in(imm_in), .alu_op_in(alu_op_in),
        .reg_wen_in(reg_wen_in), .mem_read_in(mem_read_in),
        .mem_rd(mem_rd), .mem_data(mem_data), .mem_wen(mem_wen),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_wen(wb_wen),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .opA(opA), .opB(opB), .imm_out(imm_out), .rd_out(rd_out),
        .alu_op_out(alu_op_out), .reg_wen_out(reg_wen_out), .mem_read_out(mem_read_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] a, b, imm;
        logic [3:0]  op;
        logic        wen, mrd;
        logic [4:0]  m_idx;
        logic [31:0] m_data;
        logic        m_wen;
        logic [4:0]  w_idx;
        logic [31:0] w_data;
        logic        w_wen;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        rs1 = v.rs1; rs2 = v.rs2; rd_in = v.rd;
        dataA = v.a; dataB = v.b; imm_in = v.imm;
        alu_op_in = v.op; reg_wen_in = v.wen; mem_read_in = v.mrd;
        mem_rd = v.m_idx; mem_data = v.m_data; mem_wen = v.m_wen;
        wb_rd = v.w_idx; wb_data = v.w_data; wb_wen = v.w_wen;
    endtask

    task automatic set_instr(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic [31:0] a, input logic [31:0] b, input logic mrd);
        rs1 = r1; rs2 = r2; rd_in = rd; dataA = a; dataB = b;
        imm_in = 32'h4; alu_op_in = 4'd0; reg_wen_in = 1'b1; mem_read_in = mrd;
        mem_wen = 1'b0; wb_wen = 1'b0; mem_rd = 5'd0; wb_rd = 5'd0;
        mem_data = 32'h0; wb_data = 32'h0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " opA"}, opA, 32'd0);
        check({tag, " rd_out"}, {27'd0, rd_out}, 32'd0);
        check({tag, " ctrl"}, {26'd0, alu_op_out, reg_wen_out, mem_read_out}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{5'd5, 5'd6, 5'd20, 32'h11, 32'h22, 32'h100, 4'd0, 1'b1, 1'b0,
                    5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 1'b1, 32'hAA, 32'h22};
        vecs[1] = '{5'd3, 5'd0, 5'd21, 32'h33, 32'hFFFF, 32'hFFFF_FFFC, 4'd1, 1'b1, 1'b0,
                    5'd0, 32'h0, 1'b0, 5'd0, 32'h77, 1'b1, 32'h33, 32'h0};
        vecs[2] = '{5'd4, 5'd8, 5'd0, 32'h44, 32'h88, 32'h8, 4'd2, 1'b0, 1'b0,
                    5'd4, 32'hCAFE, 1'b0, 5'd8, 32'hBEEF, 1'b1, 32'h44, 32'hBEEF};
        vecs[3] = '{5'd10, 5'd10, 5'd10, 32'h1, 32'h2, 32'h7FF, 4'd5, 1'b1, 1'b0,
                    5'd10, 32'h1010, 1'b1, 5'd0, 32'h0, 1'b0, 32'h1010, 32'h1010};
        vecs[4] = '{5'd0, 5'd0, 5'd1, 32'hDEAD, 32'hBEEF, 32'h0, 4'd7, 1'b1, 1'b0,
                    5'd0, 32'h5, 1'b1, 5'd0, 32'h6, 1'b1, 32'h0, 32'h0};
        vecs[5] = '{5'd31, 5'd30, 5'd31, 32'h1F, 32'h1E, 32'h8000_0000, 4'd8, 1'b1, 1'b0,
                    5'd30, 32'h300, 1'b1, 5'd31, 32'h310, 1'b1, 32'h310, 32'h300};
        vecs[6] = '{5'd2, 5'd1, 5'd12, 32'hFFFF_FFFF, 32'h0, 32'h1234, 4'd15, 1'b1, 1'b1,
                    5'd1, 32'hA5A5_A5A5, 1'b1, 5'd2, 32'h1234_5678, 1'b1, 32'h1234_5678, 32'hA5A5_A5A5};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        set_instr(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        #1;
        check_idle("reset");
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table-driven single transfers, back to back with out_ready=1
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            step();
            $display("vec %0d: opA=0x%0h opB=0x%0h rd=%0d op=%0d", i, opA, opB, rd_out, alu_op_out);
            check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d opA", i), opA, vecs[i].exp_a);
            check($sformatf("vec%0d opB", i), opB, vecs[i].exp_b);
            check($sformatf("vec%0d imm", i), imm_out, vecs[i].imm);
            check($sformatf("vec%0d rd", i), {27'd0, rd_out}, {27'd0, vecs[i].rd});
            check($sformatf("vec%0d ctrl", i), {26'd0, alu_op_out, reg_wen_out, mem_read_out},
                  {26'd0, vecs[i].op, vecs[i].wen, vecs[i].mrd});
        end

        // Consumed with no new transfer: drops to a zeroed bubble
        in_valid = 1'b0;
        step();
        check_idle("drain");

        // Load-use hazard: load rd=7 in output, dependent instruction waits one bubble
        set_instr(5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 1'b1);
        in_valid = 1'b1;
        step();
        check("lu load valid", {31'd0, out_valid}, 32'd1);
        check("lu load mem_read", {31'd0, mem_read_out}, 32'd1);
        set_instr(5'd7, 5'd3, 5'd9, 32'h70, 32'h30, 1'b0);
        wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 32'h700;
        #1;
        check("lu hazard in_ready", {31'd0, in_ready}, 32'd0);
        step();
        $display("load-use: bubble out_valid=%0d in_ready=%0d", out_valid, in_ready);
        check("lu bubble out_valid", {31'd0, out_valid}, 32'd0);
        check("lu bubble in_ready", {31'd0, in_ready}, 32'd0);
        check("lu bubble ctrl", {26'd0, alu_op_out, reg_wen_out, mem_read_out}, 32'd0);
        step();
        check("lu resume in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("lu accepted valid", {31'd0, out_valid}, 32'd1);
        check("lu accepted opA", opA, 32'h700);
        check("lu accepted rd", {27'd0, rd_out}, 32'd9);

        // Stall for 3 cycles with WB snoop of held rs1=9 in the second
        set_instr(5'd9, 5'd4, 5'd5, 32'h99, 32'h44, 1'b0);
        in_valid = 1'b1;
        step();
        check("stall opA initial", opA, 32'h99);
        out_ready = 1'b0;
        set_instr(5'd13, 5'd14, 5'd6, 32'h5555, 32'h6666, 1'b0);
        #1;
        check("stall in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("stall c1 opA", opA, 32'h99);
        check("stall c1 rd", {27'd0, rd_out}, 32'd5);
        wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 32'h1234;
        step();
        check("stall c2 opA snoop", opA, 32'h1234);
        check("stall c2 opB kept", opB, 32'h44);
        wb_wen = 1'b0;
        step();
        $display("stall: consumed opA=0x%0h valid=%0d", opA, out_valid);
        check("stall c3 valid", {31'd0, out_valid}, 32'd1);
        check("stall consumed opA", opA, 32'h1234);
        out_ready = 1'b1;
        #1;
        check("stall release in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("stall next rd", {27'd0, rd_out}, 32'd6);
        check("stall next opA", opA, 32'h5555);

        // Flush with in_valid and out_valid both set
        set_instr(5'd15, 5'd16, 5'd17, 32'hF0, 32'hF1, 1'b0);
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b0;
        #1;
        check("flush in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check_idle("flush");
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("flush nothing captured", {31'd0, out_valid}, 32'd0);

        // Reset mid-stall drops the held instruction
        set_instr(5'd3, 5'd4, 5'd11, 32'h31, 32'h41, 1'b0);
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        check("rst stall held", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("rst stall");
        rst_n = 1'b1;
        #1;
        check("rst stall in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("rst stall stays empty", {31'd0, out_valid}, 32'd0);

        // Reset mid-BUBBLE returns to RUN immediately
        out_ready = 1'b1;
        set_instr(5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 1'b1);
        in_valid = 1'b1;
        step();
        set_instr(5'd7, 5'd0, 5'd8, 32'h77, 32'h0, 1'b0);
        step();
        check("rst bubble entered", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_idle("rst bubble");
        rst_n = 1'b1;
        #1;
        $display("reset in bubble: in_ready=%0d out_valid=%0d", in_ready, out_valid);
        check("rst bubble in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("rst bubble accept", {31'd0, out_valid}, 32'd1);
        check("rst bubble opA", opA, 32'h77);

        in_valid = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of operands and immediate.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1: decode-side handshake.
REQ-005 SHALL have ports rs1, rs2, rd_in  input  5 each: decoded register indices.
REQ-006 SHALL have ports dataA, dataB  input  WIDTH each: register-file read data for rs1/rs2.
REQ-007 SHALL have ports imm_in input WIDTH, alu_op_in input 4, reg_wen_in input 1, mem_read_in input 1.
REQ-008 SHALL have ports mem_rd input 5, mem_data input WIDTH, mem_wen input 1: MEM-stage bypass source.
REQ-009 SHALL have ports wb_rd input 5, wb_data input WIDTH, wb_wen input 1: writeback bypass (same values driven to register-file rd/data_des/reg_wen).
REQ-010 SHALL have port flush  input  1: discard held and incoming instruction.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1: execute-side handshake.
REQ-012 SHALL have outputs opA, opB, imm_out (WIDTH), rd_out (5), alu_op_out (4), reg_wen_out, mem_read_out (1), all registered.

Function
REQ-013 Operand select per source (rs1->opA, rs2->opB): index 0 -> 0; else mem_wen & mem_rd match -> mem_data; else wb_wen & wb_rd match -> wb_data; else register-file data.
REQ-014 Transfer in on in_valid & in_ready; out consumed on out_valid & out_ready; latency 1 cycle, one entry deep.
REQ-015 in_ready = (!out_valid | out_ready) & state==RUN & !hazard, combinational.
REQ-016 hazard = out_valid & mem_read_out & rd_out!=0 & (rd_out==rs1 | rd_out==rs2) & in_valid.
REQ-017 FSM states RUN, BUBBLE; RUN->BUBBLE when hazard & out_ready; BUBBLE->RUN unconditionally next cycle.
REQ-018 On RUN->BUBBLE edge out_valid SHALL go 0 (bubble inserted); in BUBBLE in_ready=0 and out_valid stays 0.
REQ-019 If out_valid & !out_ready, all outputs SHALL hold, except opA/opB snoop: when wb_wen & wb_rd==held rs index & index!=0, held operand replaced by wb_data.
REQ-020 Held rs1/rs2 indices SHALL be registered internally for snooping.
REQ-021 If out consumed and no new transfer, out_valid SHALL fall to 0 next cycle.
REQ-022 flush SHALL force out_valid=0 and state=RUN next cycle, override in_valid and hazard; in_ready=0 during flush cycle.
REQ-023 Simultaneous mem and wb match on same index: mem_data wins (younger).
REQ-024 Control outputs SHALL be zero whenever out_valid=0 (bubbles are no-ops).

Reset
REQ-025 rst_n low SHALL asynchronously clear state to RUN and out_valid, opA, opB, imm_out, rd_out, alu_op_out, reg_wen_out, mem_read_out and held indices to 0.
REQ-026 Reset asserted mid-stall SHALL drop the held instruction; after release in_ready=1 on first cycle with out_valid=0.

Structure
REQ-027 WIDTH default, alu_op encoding constants and RUN/BUBBLE state encoding SHALL reside in shared package riscv_pkg.
REQ-028 Operand-select logic SHALL be one sub-module fwd_mux, instantiated twice (opA, opB).

Verification
REQ-029 rs1=5 (dataA=0x11), mem_wen=1 mem_rd=5 mem_data=0xAA, wb_wen=1 wb_rd=5 wb_data=0xBB -> opA=0xAA next cycle.
REQ-030 rs2=0, dataB=0xFFFF, wb_rd=0 wb_wen=1 -> opB=0.
REQ-031 Load in out (mem_read_out=1, rd_out=7), new in_valid rs1=7, out_ready=1 -> in_ready=0, one out_valid=0 cycle, instruction accepted cycle after.
REQ-032 out_ready=0 for 3 cycles holding rs1=9, wb_wen=1 wb_rd=9 wb_data=0x1234 in cycle 2 -> opA=0x1234 when finally consumed.
REQ-033 flush=1 with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, nothing captured.
REQ-034 rst_n low mid-BUBBLE -> all outputs 0 immediately, state RUN, in_ready=1 after release.
